digit_serial_addsub: RTL and testbench

- Parametrised successor to the digit-serial adder. Adds or subtracts two N-digit, W-bit-per-digit two's-complement words, least-significant digit (LSD) first.
- Adds a per-word add/subtract mode, a valid qualifier on the input stream, an internal digit counter that generates end-of-word, and registered carry/overflow status.
- Sits between digit-serial producers and consumers in the arithmetic datapath experiments.

---
 rtl/digit_serial_pkg.sv | 14 +
 rtl/digit_addsub_cell.sv | 29 ++
 rtl/digit_serial_addsub.sv | 138 +++++++++++++
 tb/tb_digit_serial_addsub.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial add/subtract datapath.
package digit_serial_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Digit counter width: enough bits to count 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/digit_addsub_cell.sv
// One digit of a ripple add/subtract; also exposes the carry into the MSB
// so the word-level signed overflow can be formed on the last digit.
module digit_addsub_cell #(
   parameter int W = 3
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   input  logic         cin,
   output logic [W-1:0] d,
   output logic         cout,
   output logic         c_msb
);

   logic [W-1:0] b_x;
   logic [W-1:0] low_sum;
   logic [1:0]   msb_sum;

   always_comb begin
      b_x     = sub ? ~b : b;
      // Low W-1 bits summed one bit wider so the top bit is the carry into bit W-1.
      low_sum = {1'b0, a[W-2:0]} + {1'b0, b_x[W-2:0]} + {{(W-1){1'b0}}, cin};
      c_msb   = low_sum[W-1];
      msb_sum = {1'b0, a[W-1]} + {1'b0, b_x[W-1]} + {1'b0, c_msb};
      cout    = msb_sum[1];
      d       = {msb_sum[0], low_sum[W-2:0]};
   end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, LSD first, with per-word
// mode, input valid qualifier, internal end-of-word counter and status flags.
module digit_serial_addsub
   import digit_serial_pkg::*;
#(
   parameter int W = 3,
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         aresetn,
   input  logic         in_valid,
   input  logic         first_digit,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   output logic [W-1:0] s,
   output logic         out_last,
   output logic         carry_out,
   output logic         overflow,
   output logic         err
);

   localparam int CNT_W = cnt_w(N);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               mode_q, mode_d;
   logic [W-1:0]       s_q, s_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic               carry_out_q, carry_out_d;
   logic               overflow_q, overflow_d;
   logic               err_q, err_d;

   logic               start;
   logic               cell_sub, cell_cin, cell_cout, cell_c_msb;
   logic [W-1:0]       cell_d;
   logic               accept, last;

   // A first digit takes its mode from the port, and the carry-in equals the mode
   // (the +1 of the two's-complement negation when subtracting).
   assign start    = in_valid & first_digit;
   assign cell_sub = start ? sub : mode_q;
   assign cell_cin = start ? sub : carry_q;

   digit_addsub_cell #(.W(W)) u_cell (
      .a     (a),
      .b     (b),
      .sub   (cell_sub),
      .cin   (cell_cin),
      .d     (cell_d),
      .cout  (cell_cout),
      .c_msb (cell_c_msb)
   );

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      mode_d      = mode_q;
      accept      = 1'b0;
      last        = 1'b0;
      err_d       = 1'b0;

      if (in_valid) begin
         if (first_digit) begin
            accept = 1'b1;
            mode_d = sub;
            err_d  = (state_q == RUN);
            if (N == 1) begin
               last    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               state_d = RUN;
               cnt_d   = CNT_W'(1);
            end
         end else if (state_q == RUN) begin
            accept = 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
               last    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            err_d = 1'b1;
         end
      end

      if (accept) carry_d = cell_cout;

      s_d         = accept ? cell_d : '0;
      out_valid_d = accept;
      out_last_d  = last;
      carry_out_d = last & cell_cout;
      overflow_d  = last & (cell_c_msb ^ cell_cout);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         mode_q      <= 1'b0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         mode_q      <= mode_d;
         s_q         <= s_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         err_q       <= err_d;
      end
   end

   assign s         = s_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign err       = err_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench: word-level arithmetic model versus the serial datapath,
// with directed cases, protocol violations, gaps, resets and random traffic.
module tb_digit_serial_addsub;

   localparam int W  = 3;
   localparam int N  = 2;
   localparam int WN = W * N;

   typedef struct {
      logic [WN-1:0] sum;
      logic          c;
      logic          v;
   } res_t;

   logic         clk = 1'b0;
   logic         aresetn = 1'b0;
   logic         in_valid = 1'b0;
   logic         first_digit = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic [W-1:0] s;
   logic         out_last;
   logic         carry_out;
   logic         overflow;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   // Observed-traffic bookkeeping, filled by the monitor
   res_t          results[$];
   int            n_err   = 0;
   int            n_valid = 0;
   int            n_bad   = 0;
   int            pos     = 0;
   logic [WN-1:0] cur     = '0;

   digit_serial_addsub #(.W(W), .N(N)) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .in_valid    (in_valid),
      .first_digit (first_digit),
      .sub         (sub),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .s           (s),
      .out_last    (out_last),
      .carry_out   (carry_out),
      .overflow    (overflow),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Reassemble output words from the digit stream, sampled 1 ns after the edge.
   always @(posedge clk) begin
      #1;
      if (!aresetn) begin
         pos = 0;
         cur = '0;
      end else begin
         if (err) begin
            n_err++;
            pos = 0;
            cur = '0;
         end
         if (!out_last && (carry_out || overflow)) n_bad++;
         if (out_valid) begin
            n_valid++;
            if (pos < N) cur[pos*W +: W] = s;
            pos++;
            if (out_last) begin
               results.push_back('{cur, carry_out, overflow});
               pos = 0;
               cur = '0;
            end
         end
      end
   end

   // Word-level reference from plain integer arithmetic
   function automatic res_t model(input logic [WN-1:0] x, input logic [WN-1:0] y, input logic sb);
      res_t   r;
      longint m  = longint'(1) << WN;
      longint ux = longint'(x);
      longint uy = longint'(y);
      longint sx = x[WN-1] ? ux - m : ux;
      longint sy = y[WN-1] ? uy - m : uy;
      longint ru = sb ? ux - uy : ux + uy;
      longint rs = sb ? sx - sy : sx + sy;
      r.sum = WN'(((ru % m) + m) % m);
      r.c   = sb ? (ux >= uy) : (ru >= m);
      r.v   = (rs > (m / 2 - 1)) || (rs < -(m / 2));
      return r;
   endfunction

   task automatic drive(input logic v, input logic f, input logic sb,
                        input logic [W-1:0] da, input logic [W-1:0] db);
      @(negedge clk);
      in_valid    = v;
      first_digit = f;
      sub         = sb;
      a           = da;
      b           = db;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, W'($urandom), W'($urandom));
   endtask

   task automatic send_word(input logic [WN-1:0] x, input logic [WN-1:0] y, input logic sb,
                            input int gap_at, input int idle_after);
      for (int i = 0; i < N; i++) begin
         if (i == gap_at) idle(1);
         drive(1'b1, (i == 0), sb, x[i*W +: W], y[i*W +: W]);
      end
      idle(idle_after);
   endtask

   task automatic get_result(output res_t r, output bit ok);
      ok = (results.size() != 0);
      if (ok) r = results.pop_front();
      else r = '{'0, 1'b0, 1'b0};
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      idle(3);
      n_tests++;
      if ({out_valid, s, out_last, carry_out, overflow, err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h expected 0",
                  {out_valid, s, out_last, carry_out, overflow, err});
      end
      aresetn = 1'b1;
      idle(2);
   endtask

   task automatic test_directed();
      logic [WN-1:0] ta [5] = '{6'd1, 6'd5, 6'd31, 6'd63, 6'd2};
      logic [WN-1:0] tb [5] = '{6'd2, 6'd7, 6'd1,  6'd1,  6'd2};
      logic          ts [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int            ti [5] = '{3, 3, 3, 0, 3};
      logic [WN-1:0] es [5] = '{6'd3, 6'd62, 6'd32, 6'd0, 6'd4};
      logic          ec [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic          ev [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      res_t r;
      bit   ok;
      for (int i = 0; i < 5; i++) send_word(ta[i], tb[i], ts[i], -1, ti[i]);
      for (int i = 0; i < 5; i++) begin
         get_result(r, ok);
         n_tests++;
         if (!ok || {r.sum, r.c, r.v} !== {es[i], ec[i], ev[i]}) begin
            n_fail++;
            $display("FAIL directed_%0d: got sum=%0d c=%0b v=%0b (present=%0b) expected sum=%0d c=%0b v=%0b",
                     i, r.sum, r.c, r.v, ok, es[i], ec[i], ev[i]);
         end
      end
   endtask

   task automatic test_protocol();
      int   e0, v0, r0;
      res_t r, exp_r;
      bit   ok;
      logic [WN-1:0] x, y;
      // Stray digit while idle
      e0 = n_err;
      v0 = n_valid;
      drive(1'b1, 1'b0, 1'b0, W'($urandom), W'($urandom));
      idle(3);
      n_tests++;
      if ((n_err - e0) != 1 || (n_valid - v0) != 0) begin
         n_fail++;
         $display("FAIL idle_stray_digit: got err=%0d valid=%0d expected err=1 valid=0",
                  n_err - e0, n_valid - v0);
      end
      // Restart in the middle of a word
      x = WN'($urandom);
      y = WN'($urandom);
      exp_r = model(x, y, 1'b1);
      e0 = n_err;
      r0 = results.size();
      drive(1'b1, 1'b1, 1'b0, W'(5), W'(5));
      send_word(x, y, 1'b1, -1, 3);
      n_tests++;
      if ((n_err - e0) != 1 || (results.size() - r0) != 1) begin
         n_fail++;
         $display("FAIL abort_counts: got err=%0d words=%0d expected err=1 words=1",
                  n_err - e0, results.size() - r0);
      end
      get_result(r, ok);
      n_tests++;
      if (!ok || {r.sum, r.c, r.v} !== {exp_r.sum, exp_r.c, exp_r.v}) begin
         n_fail++;
         $display("FAIL abort_restart_word: got sum=%0d c=%0b v=%0b expected sum=%0d c=%0b v=%0b",
                  r.sum, r.c, r.v, exp_r.sum, exp_r.c, exp_r.v);
      end
   endtask

   task automatic test_gap();
      logic [WN-1:0] x, y;
      logic          sb;
      res_t          r_gap, r_plain, exp_r;
      bit            ok1, ok2;
      x  = WN'($urandom);
      y  = WN'($urandom);
      sb = 1'($urandom);
      exp_r = model(x, y, sb);
      send_word(x, y, sb, 1, 3);
      get_result(r_gap, ok1);
      send_word(x, y, sb, -1, 3);
      get_result(r_plain, ok2);
      n_tests++;
      if (!ok1 || {r_gap.sum, r_gap.c, r_gap.v} !== {exp_r.sum, exp_r.c, exp_r.v}) begin
         n_fail++;
         $display("FAIL gap_word: got sum=%0d c=%0b v=%0b expected sum=%0d c=%0b v=%0b",
                  r_gap.sum, r_gap.c, r_gap.v, exp_r.sum, exp_r.c, exp_r.v);
      end
      n_tests++;
      if (!ok2 || {r_plain.sum, r_plain.c, r_plain.v} !== {r_gap.sum, r_gap.c, r_gap.v}) begin
         n_fail++;
         $display("FAIL gap_vs_plain: got sum=%0d expected sum=%0d", r_plain.sum, r_gap.sum);
      end
   endtask

   task automatic test_reset_mid();
      int   r0;
      res_t r;
      bit   ok;
      r0 = results.size();
      drive(1'b1, 1'b1, 1'b0, W'(1), W'(2));
      @(posedge clk);
      #2;
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got out_valid=%0b expected 1", out_valid);
      end
      aresetn  = 1'b0;
      in_valid = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, s, out_last, carry_out, overflow, err} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %0h expected 0",
                  {out_valid, s, out_last, carry_out, overflow, err});
      end
      idle(2);
      aresetn = 1'b1;
      drive(1'b1, 1'b0, 1'b0, W'(0), W'(0));
      idle(3);
      n_tests++;
      if (results.size() != r0) begin
         n_fail++;
         $display("FAIL reset_mid_no_last: got words=%0d expected 0", results.size() - r0);
      end
      send_word(WN'(1), WN'(2), 1'b0, -1, 3);
      get_result(r, ok);
      n_tests++;
      if (!ok || {r.sum, r.c, r.v} !== {WN'(3), 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_fresh: got sum=%0d c=%0b v=%0b expected sum=3 c=0 v=0",
                  r.sum, r.c, r.v);
      end
   endtask

   task automatic test_random();
      res_t expq[$];
      res_t r, e;
      bit   ok;
      logic [WN-1:0] x, y;
      logic sb;
      for (int i = 0; i < 60; i++) begin
         x  = WN'($urandom);
         y  = WN'($urandom);
         sb = 1'($urandom);
         expq.push_back(model(x, y, sb));
         send_word(x, y, sb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N - 1)) : -1,
                   $urandom_range(0, 2));
      end
      idle(3);
      n_tests++;
      if (results.size() != expq.size()) begin
         n_fail++;
         $display("FAIL random_count: got %0d words expected %0d", results.size(), expq.size());
      end
      while (expq.size() != 0) begin
         e = expq.pop_front();
         get_result(r, ok);
         n_tests++;
         if (!ok || {r.sum, r.c, r.v} !== {e.sum, e.c, e.v}) begin
            n_fail++;
            $display("FAIL random_word: got sum=%0d c=%0b v=%0b expected sum=%0d c=%0b v=%0b",
                     r.sum, r.c, r.v, e.sum, e.c, e.v);
         end
      end
      n_tests++;
      if (n_bad != 0) begin
         n_fail++;
         $display("FAIL flags_outside_last: got %0d cycles expected 0", n_bad);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_protocol();
      test_gap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
